// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg
// Purpose : default 640x480@60 Hz VGA timing constants shared by the timing
//           generator and the downstream pixel/ROM/palette stages.
// Contents: DEF_* porch/sync/visible sizes, derived totals, sync windows,
//           coordinate type and a window-decode helper.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_BOTTOM  = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_TOP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_BOTTOM + DEF_V_SYNC + DEF_V_TOP;

  // Inclusive sync windows in counter coordinates.
  localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Unsigned inclusive window test on a 10-bit coordinate.
  function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_if
// Purpose : bundles the raster timing signals between the generator and the
//           pixel stage.
// Signals : en (pixel advance), hpos/vpos (current coordinate), display_on,
//           hsync/vsync (delayed sync), line_start/frame_start (strobes),
//           frame_cnt (completed frames).
// Modports: master = timing generator, slave = downstream consumer.
//
// Handshake: there is no valid/ready pair. en is a per-cycle qualifier from
// the consumer side: every clk with en=1 advances one pixel, en=0 freezes the
// counters. All other signals are decoded from the current counter state and
// are valid every cycle; the strobes are qualified by en so a consumer may
// treat them as single-pixel events.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic       en;
  coord_t     hpos;
  coord_t     vpos;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  en,
    output hpos, vpos, display_on, hsync, vsync,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  hpos, vpos, display_on, hsync, vsync,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// vga_sync_delay
// Purpose : N-stage shift register with asynchronous reset to a fixed level;
//           realigns a raw sync with registered RGB further down the path.
// Ports   : clk, rst_n (async active-low), i_d (raw level), o_q (delayed).
module vga_sync_delay #(
  parameter int   N         = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sh;

  // Shifts every clk, independent of pixel enable, so latency is in clk units.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= {N{RESET_VAL}};
    end else begin
      r_sh[0] <= i_d;
      for (int i = 1; i < N; i++) begin
        r_sh[i] <= r_sh[i-1];
      end
    end
  end

  assign o_q = r_sh[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Purpose : VGA raster timing. Horizontal/vertical counters advance on en,
//           coordinates and display window are decoded combinationally, sync
//           pulses are delayed SYNC_DELAY clks to meet registered RGB.
// Ports   : clk, rst_n (async active-low), vga (vga_timing_if.master:
//           en in; hpos, vpos, display_on, hsync, vsync, line_start,
//           frame_start, frame_cnt out).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY   = DEF_H_DISPLAY,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_DISPLAY   = DEF_V_DISPLAY,
  parameter int   V_BOTTOM    = DEF_V_BOTTOM,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_TOP       = DEF_V_TOP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   SYNC_DELAY  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_timing_if.master    vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  // Counters are 10 bits; anything larger cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 1..4");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_BOTTOM);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  coord_t     r_hpos;
  coord_t     r_vpos;
  logic [7:0] r_frame_cnt;

  logic w_h_last;
  logic w_v_last;
  logic w_hsync_lvl;
  logic w_vsync_lvl;
  logic w_hsync;
  logic w_vsync;

  assign w_h_last = (r_hpos == H_LAST);
  assign w_v_last = (r_vpos == V_LAST);

  // Both wraps and the frame increment share one edge at the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hpos      <= '0;
      r_vpos      <= '0;
      r_frame_cnt <= '0;
    end else if (vga.en) begin
      if (w_h_last) begin
        r_hpos <= '0;
        if (w_v_last) begin
          r_vpos      <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_vpos <= r_vpos + 10'd1;
        end
      end else begin
        r_hpos <= r_hpos + 10'd1;
      end
    end
  end

  // Raw sync as an output level; the delay line resets to the inactive level.
  assign w_hsync_lvl = in_window(r_hpos, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign w_vsync_lvl = in_window(r_vpos, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  vga_sync_delay #(.N(SYNC_DELAY), .RESET_VAL(~SYNC_ACTIVE)) u_hsync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_hsync_lvl),
    .o_q   (w_hsync)
  );

  vga_sync_delay #(.N(SYNC_DELAY), .RESET_VAL(~SYNC_ACTIVE)) u_vsync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_vsync_lvl),
    .o_q   (w_vsync)
  );

  assign vga.hpos        = r_hpos;
  assign vga.vpos        = r_vpos;
  assign vga.frame_cnt   = r_frame_cnt;
  assign vga.display_on  = (r_hpos < H_VIS) && (r_vpos < V_VIS);
  assign vga.line_start  = vga.en && (r_hpos == 10'd0);
  assign vga.frame_start = vga.en && (r_hpos == 10'd0) && (r_vpos == 10'd0);
  assign vga.hsync       = w_hsync;
  assign vga.vsync       = w_vsync;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster for the TinyVGA output path. It runs horizontal and vertical counters and produces pixel coordinates and a `display_on` window for the pixel/ROM/palette stage directly downstream. It also produces sync pulses delayed to line up with that stage's one-cycle registered RGB, plus line/frame strobes and a frame counter for animation. It replaces the ad-hoc sync generator, adding a pixel-enable and configurable sync latency.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch
- `V_DISPLAY`, 480, visible lines
- `V_BOTTOM`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_TOP`, 33, vertical back porch
- `SYNC_ACTIVE`, 0, active level of hsync/vsync
- `SYNC_DELAY`, 1, register stages on hsync/vsync (range 1..4)

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset. Clock is `clk`, reset is `rst_n`, one clock domain.
- `en` in 1: pixel advance enable. Tie to 1 for a 25.175 MHz `clk`.
- `hpos` out 10: current column, 0..799.
- `vpos` out 10: current line, 0..524.
- `display_on` out 1: hpos<H_DISPLAY && vpos<V_DISPLAY.
- `hsync` out 1: delayed horizontal sync.
- `vsync` out 1: delayed vertical sync.
- `line_start` out 1: `en && hpos==0`.
- `frame_start` out 1: `en && hpos==0 && vpos==0`.
- `frame_cnt` out 8: completed-frame counter.

## Operation
- **Totals:** H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- **Horizontal counter:** with `en`=1, hpos increments each clk. At H_TOTAL-1 it wraps to 0 and vpos advances.
- **Vertical counter:** at V_TOTAL-1 with hpos at H_TOTAL-1, vpos wraps to 0 and frame_cnt increments. frame_cnt wraps 255→0.
- **Hold:** with `en`=0, hpos, vpos and frame_cnt hold.
- **Raw sync, horizontal:** raw_h is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751].
- **Raw sync, vertical:** raw_v is active for vpos in [V_DISPLAY+V_BOTTOM, +V_SYNC-1], i.e. [490,491].
- **Sync outputs:** hsync/vsync are raw_h/raw_v passed through SYNC_DELAY register stages. Stages shift every clk regardless of `en`. Output level is SYNC_ACTIVE when active, otherwise its inverse.
- **Combinational outputs:** display_on, line_start and frame_start decode the current registered counters. They have no extra latency.
- **Width rules:** all compares are unsigned 10-bit. Parameters must satisfy H_TOTAL, V_TOTAL ≤ 1024; violation is an elaboration error.

## Timing
- **Reset values (async on rst_n low):**
  - hpos=0, vpos=0, frame_cnt=0.
  - All sync delay stages hold the inactive level, so hsync=vsync=~SYNC_ACTIVE (1 by default).
  - display_on=1 and line_start/frame_start follow `en`, since counters sit at (0,0).
- **Reset mid-frame:** outputs go to reset values immediately. The first `en` cycle after release is counted as pixel (0,0); hpos=1 follows on the next enabled edge.
- **Counter latency:** hpos/vpos change on the clk edge where `en`=1.
- **Sync latency:** the sync edge for column 656 appears SYNC_DELAY clks after hpos becomes 656. Default: one clk, matching the downstream registered RGB.
- **Simultaneous wraps:** at (799,524) with `en`, the next state is (0,0) and frame_cnt+1, all on the same edge.
- **`en` deasserted mid-sync:** sync pulses stretch in clk terms but cover exactly H_SYNC/V_SYNC enabled pixels.

## Structure
- Package `vga_timing_pkg` holds the default 640x480 timing constants, derived H_TOTAL/V_TOTAL, and sync window start/end localparams. Downstream stages share these.
- Sub-module `vga_sync_delay` is a parameterised N-stage shift register with async reset to a given value. It is instantiated once per sync signal.
- Counters and decode live in the top block.

## Test plan
- **Reset:** hold rst_n=0 with `en`=1.
  - Expect hpos=0, vpos=0, frame_cnt=0, hsync=vsync=1.
  - Release; after 5 clks expect hpos=5.
- **One line, `en`=1, default params:**
  - hsync is low for exactly 96 clks, starting at the clk after hpos==656.
  - display_on is high for hpos 0..639.
  - line_start pulses once per 800 clks.
- **Full frame:**
  - vsync is low for 1600 clks, starting one clk after (0,490).
  - frame_start pulses every 420000 clks.
  - frame_cnt goes 0→1 on the edge after (799,524).
- **`en` toggling 1,0,1,0:** hpos advances every second clk, and one line takes 1600 clks. hsync low spans 192 clks.
- **frame_cnt wrap:** after 256 frames (or force near state via fast params V_DISPLAY=4, H_DISPLAY=8), frame_cnt returns to 0.
- **Async reset mid-frame:** assert rst_n low at (300,200) between clk edges.
  - Outputs are at reset values before the next edge.
  - Counting resumes from (0,0) after release.
